// File: rtl/riscv_bp_pkg.sv
// rtl/riscv_bp_pkg.sv - shared encodings and constants for the branch predictor
package riscv_bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_cnt_e;

  localparam logic [1:0]  CNT_RESET = WNT;
  localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/bp_sat_counter2.sv
// rtl/bp_sat_counter2.sv - 2-bit saturating counter next-state function
module bp_sat_counter2
  import riscv_bp_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] next
);

  always_comb begin
    next = cur;
    if (taken) begin
      if (cur != ST) next = cur + 2'd1;
    end else begin
      if (cur != SNT) next = cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - BHT/BTB branch predictor with EX-stage training and redirect
// Optional BTB tag storage and matching is enabled by defining BP_BTB_TAG_EN.
module branch_predict_unit
  import riscv_bp_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [PC_W-1:0]  if_pc,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic             ex_taken,
  input  logic [PC_W-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic [PC_W-1:0]  ex_pred_target,
  output logic             redirect,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0]      cnt_q        [ENTRIES];
  logic            btb_valid_q  [ENTRIES];
  logic [PC_W-1:0] btb_target_q [ENTRIES];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic             if_tag_hit, ex_tag_hit;
  logic [1:0]       cnt_next;
  logic             br_upd, nb_clear, mis;
  logic [PC_W-1:0]  if_pc_next, ex_pc_next;

  assign if_idx     = if_pc[IDX_W+1:2];
  assign ex_idx     = ex_pc[IDX_W+1:2];
  assign if_pc_next = if_pc + PC_W'(PC_STEP);
  assign ex_pc_next = ex_pc + PC_W'(PC_STEP);

`ifdef BP_BTB_TAG_EN
  localparam int TAG_W = PC_W - IDX_W - 2;
  logic [TAG_W-1:0] btb_tag_q [ENTRIES];

  assign if_tag_hit = (btb_tag_q[if_idx] == if_pc[PC_W-1:IDX_W+2]);
  assign ex_tag_hit = (btb_tag_q[ex_idx] == ex_pc[PC_W-1:IDX_W+2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ENTRIES; k++) btb_tag_q[k] <= '0;
    end else if (br_upd && ex_taken) begin
      btb_tag_q[ex_idx] <= ex_pc[PC_W-1:IDX_W+2];
    end
  end
`else
  // Without tags every PC that shares an index aliases onto the same entry.
  assign if_tag_hit = 1'b1;
  assign ex_tag_hit = 1'b1;
`endif

  // Lookup reads the registered tables, so a same-cycle update is seen next cycle.
  assign pred_taken  = if_valid & btb_valid_q[if_idx] & if_tag_hit & cnt_q[if_idx][1];
  assign pred_target = pred_taken ? btb_target_q[if_idx] : if_pc_next;

  assign br_upd   = ex_valid & ex_branch;
  assign nb_clear = ex_valid & ~ex_branch & ex_pred_taken & ex_tag_hit;
  assign mis      = ex_valid & (ex_branch
                      ? ((ex_taken != ex_pred_taken) |
                         (ex_taken & ex_pred_taken & (ex_target != ex_pred_target)))
                      : ex_pred_taken);

  bp_sat_counter2 u_cnt (
    .cur   (cnt_q[ex_idx]),
    .taken (ex_taken),
    .next  (cnt_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < ENTRIES; k++) begin
        cnt_q[k]        <= CNT_RESET;
        btb_valid_q[k]  <= 1'b0;
        btb_target_q[k] <= '0;
      end
    end else if (br_upd) begin
      cnt_q[ex_idx] <= cnt_next;
      if (ex_taken) begin
        btb_valid_q[ex_idx]  <= 1'b1;
        btb_target_q[ex_idx] <= ex_target;
      end
    end else if (nb_clear) begin
      btb_valid_q[ex_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect         <= 1'b0;
      redirect_pc      <= '0;
      mispredict_count <= '0;
    end else begin
      redirect <= mis;
      if (mis) begin
        redirect_pc <= (ex_branch && ex_taken) ? ex_target : ex_pc_next;
        if (mispredict_count != {CNT_W{1'b1}}) mispredict_count <= mispredict_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - scoreboard bench for branch_predict_unit
module tb_branch_predict_unit;

  localparam int PC_W  = 32;
  localparam int IDX_W = 4;
  localparam int CNT_W = 16;
  localparam int N     = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             if_valid = 1'b0;
  logic [PC_W-1:0]  if_pc = '0;
  logic             pred_taken;
  logic [PC_W-1:0]  pred_target;
  logic             ex_valid = 1'b0;
  logic             ex_branch = 1'b0;
  logic [PC_W-1:0]  ex_pc = '0;
  logic             ex_taken = 1'b0;
  logic [PC_W-1:0]  ex_target = '0;
  logic             ex_pred_taken = 1'b0;
  logic [PC_W-1:0]  ex_pred_target = '0;
  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;
  logic [CNT_W-1:0] mispredict_count;

  branch_predict_unit #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .ex_valid         (ex_valid),
    .ex_branch        (ex_branch),
    .ex_pc            (ex_pc),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            m;
    logic [PC_W-1:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model of the tables and counters
  logic [1:0]       m_cnt   [N];
  logic             m_val   [N];
  logic [PC_W-1:0]  m_tgt   [N];
  logic [PC_W-1:0]  m_tagpc [N];
  logic [CNT_W-1:0] m_mcount;

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_cnt[k] = 2'b01; m_val[k] = 1'b0; m_tgt[k] = '0; m_tagpc[k] = '0;
    end
    m_mcount = '0;
  endtask

  function automatic logic tag_ok(input logic [PC_W-1:0] pc);
`ifdef BP_BTB_TAG_EN
    return m_tagpc[pc[IDX_W+1:2]][PC_W-1:IDX_W+2] == pc[PC_W-1:IDX_W+2];
`else
    return 1'b1;
`endif
  endfunction

  task automatic check_pred(input logic [PC_W-1:0] pc, input logic v, input string name);
    logic            et;
    logic [PC_W-1:0] eg;
    int              i;
    if_valid = v;
    if_pc    = pc;
    #1;
    i  = int'(pc[IDX_W+1:2]);
    et = v && m_val[i] && tag_ok(pc) && (m_cnt[i] >= 2'b10);
    eg = et ? m_tgt[i] : pc + 32'd4;
    n_tests++;
    if (pred_taken !== et) begin
      n_fail++; $display("FAIL %s pred_taken: got %0b want %0b", name, pred_taken, et);
    end
    n_tests++;
    if (pred_target !== eg) begin
      n_fail++; $display("FAIL %s pred_target: got %h want %h", name, pred_target, eg);
    end
  endtask

  task automatic ex_cycle(input logic v, input logic br, input logic [PC_W-1:0] pc,
                          input logic tk, input logic [PC_W-1:0] tgt,
                          input logic ptk, input logic [PC_W-1:0] ptgt,
                          input logic chk_if, input string name);
    exp_t e;
    int   j;
    @(negedge clk);
    ex_valid = v; ex_branch = br; ex_pc = pc; ex_taken = tk;
    ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
    e.m  = v && (br ? ((tk != ptk) || (tk && ptk && (tgt != ptgt))) : ptk);
    e.pc = (br && tk) ? tgt : pc + 32'd4;
    sb.push_back(e);
    if (chk_if) check_pred(if_pc, if_valid, {name, "_pre"});
    j = int'(pc[IDX_W+1:2]);
    if (e.m && m_mcount != '1) m_mcount = m_mcount + 1'b1;
    if (v && br) begin
      if (tk) m_cnt[j] = (m_cnt[j] == 2'b11) ? 2'b11 : m_cnt[j] + 2'd1;
      else    m_cnt[j] = (m_cnt[j] == 2'b00) ? 2'b00 : m_cnt[j] - 2'd1;
      if (tk) begin m_val[j] = 1'b1; m_tgt[j] = tgt; m_tagpc[j] = pc; end
    end else if (v && ptk && tag_ok(pc)) begin
      m_val[j] = 1'b0;
    end
    @(posedge clk); #1;
    ex_valid = 1'b0;
    e = sb.pop_front();
    n_tests++;
    if (redirect !== e.m) begin
      n_fail++; $display("FAIL %s redirect: got %0b want %0b", name, redirect, e.m);
    end
    if (e.m) begin
      n_tests++;
      if (redirect_pc !== e.pc) begin
        n_fail++; $display("FAIL %s redirect_pc: got %h want %h", name, redirect_pc, e.pc);
      end
    end
    n_tests++;
    if (mispredict_count !== m_mcount) begin
      n_fail++; $display("FAIL %s count: got %0d want %0d", name, mispredict_count, m_mcount);
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (redirect !== 1'b0 || redirect_pc !== 32'h0 || mispredict_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %0b/%h/%0d want 0/0/0", redirect, redirect_pc, mispredict_count);
    end
    check_pred(32'h100, 1'b1, "reset_lookup");
  endtask

  task automatic test_train();
    ex_cycle(1, 1, 32'h100, 1, 32'h200, 0, 32'h0, 0, "train_first");
    check_pred(32'h100, 1'b1, "train_lookup");
    check_pred(32'h100, 1'b0, "train_if_invalid");
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 3; k++) ex_cycle(1, 1, 32'h100, 1, 32'h200, 1, 32'h200, 0, "sat_taken");
    ex_cycle(1, 1, 32'h100, 0, 32'h200, 1, 32'h200, 0, "sat_not_taken");
    check_pred(32'h100, 1'b1, "sat_lookup");
  endtask

  task automatic test_nonbranch();
    ex_cycle(1, 0, 32'h140, 0, 32'h0, 1, 32'h200, 0, "nonbranch");
    check_pred(32'h140, 1'b1, "nonbranch_lookup");
  endtask

  task automatic test_target_mismatch();
    ex_cycle(1, 1, 32'h100, 1, 32'h200, 1, 32'h300, 0, "tgt_mismatch");
    check_pred(32'h100, 1'b1, "tgt_lookup");
  endtask

  task automatic test_collision();
    ex_cycle(1, 1, 32'h100, 0, 32'h0, 1, 32'h200, 0, "coll_setup");
    if_valid = 1'b1; if_pc = 32'h100;
    ex_cycle(1, 1, 32'h100, 0, 32'h0, 1, 32'h200, 1, "coll");
    check_pred(32'h100, 1'b1, "coll_post");
  endtask

  task automatic test_back_to_back();
    ex_cycle(1, 1, 32'h20c, 1, 32'h400, 0, 32'h0, 0, "b2b_1");
    ex_cycle(1, 1, 32'h210, 1, 32'h500, 0, 32'h0, 0, "b2b_2");
    ex_cycle(1, 0, 32'h214, 0, 32'h0, 1, 32'h600, 0, "b2b_3");
    ex_cycle(1, 1, 32'h218, 0, 32'h0, 0, 32'h0, 0, "b2b_quiet");
    ex_cycle(0, 1, 32'h228, 1, 32'h700, 0, 32'h0, 0, "ex_invalid");
    check_pred(32'h228, 1'b1, "ex_invalid_lookup");
    check_pred(32'h20c, 1'b1, "b2b_lookup");
  endtask

  task automatic test_wrap();
    ex_cycle(1, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h800, 0, "wrap");
    check_pred(32'hFFFF_FFFC, 1'b1, "wrap_lookup");
  endtask

  task automatic test_reset_mid_redirect();
    ex_cycle(1, 1, 32'h100, 1, 32'h900, 0, 32'h0, 0, "rst_mid_setup");
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    sb.delete();
    n_tests++;
    if (redirect !== 1'b0 || redirect_pc !== 32'h0 || mispredict_count !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_mid: got %0b/%h/%0d want 0/0/0", redirect, redirect_pc, mispredict_count);
    end
    @(negedge clk) rst_n = 1'b1;
    check_pred(32'h100, 1'b1, "rst_mid_lookup");
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_train();
    test_saturate();
    test_nonbranch();
    test_target_mismatch();
    test_collision();
    test_back_to_back();
    test_wrap();
    test_reset_mid_redirect();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Consumer side of the EX-stage branch decision: a direct-mapped branch history table (BHT) of 2-bit saturating counters plus a branch target buffer (BTB).
- Supplies taken/target predictions to IF.
- Takes resolved outcomes from EX (taken, target, prediction carried down the pipe), trains the tables, and issues a registered redirect/flush on misprediction.
- Sits between PC-select logic in IF and the branch decision logic in EX.

Parameters:
- PC_W, 32, program counter width in bits.
- IDX_W, 4, table index width; 2**IDX_W entries, index = pc[IDX_W+1:2].
- CNT_W, 16, width of the saturating mispredict statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_valid  in  1  IF-stage lookup request.
- if_pc  in  PC_W  fetch PC.
- pred_taken  out  1  prediction for if_pc (combinational).
- pred_target  out  PC_W  predicted target (combinational).
- ex_valid  in  1  EX-stage instruction valid.
- ex_branch  in  1  EX instruction is a conditional branch.
- ex_pc  in  PC_W  PC of EX instruction.
- ex_taken  in  1  resolved outcome from branch decision logic.
- ex_target  in  PC_W  resolved branch target.
- ex_pred_taken  in  1  prediction made in IF, carried through the pipe.
- ex_pred_target  in  PC_W  predicted target, carried through the pipe.
- redirect  out  1  one-cycle pulse: load redirect_pc into PC and flush IF/ID.
- redirect_pc  out  PC_W  corrected fetch address.
- mispredict_count  out  CNT_W  saturating mispredict count.

Behaviour:
- Reset (async, rst_n=0):
  - All counters are set to 2'b01 (weakly not-taken), all BTB valid bits are cleared, and all targets are set to 0.
  - redirect=0, redirect_pc=0, mispredict_count=0.
  - Reset asserted mid-redirect kills the pulse immediately.
- Prediction:
  - pred_taken = if_valid & btb_valid[i] & cnt[i][1], with i indexed from if_pc.
  - pred_target = btb_target[i] when pred_taken, else if_pc+4.
  - Zero-cycle latency.
- Update (rising edge, when ex_valid & ex_branch):
  - Counter at index j (from ex_pc) increments if ex_taken, otherwise decrements.
  - Counter saturates at 2'b11 and 2'b00.
  - If ex_taken: btb_target[j]=ex_target and btb_valid[j]=1.
- Non-branch hit (ex_valid & ~ex_branch & ex_pred_taken): btb_valid[j] is cleared and the counter is left unchanged.
- Mispredict condition (M) = ex_valid & one of:
  - (a) ex_branch & (ex_taken != ex_pred_taken);
  - (b) ex_branch & ex_taken & ex_pred_taken & (ex_target != ex_pred_target);
  - (c) ~ex_branch & ex_pred_taken.
- Redirect (registered, latency 1):
  - On the edge where M is true, the next cycle has redirect=1.
  - redirect_pc = (ex_branch & ex_taken) ? ex_target : ex_pc+4.
  - redirect drops to 0 the following cycle unless M holds again.
  - Back-to-back M produces consecutive pulses, each carrying the newest redirect_pc.
- Read/update collision (same cycle, same index): IF sees the pre-update value; the new value is visible next cycle.
- Arithmetic:
  - PC+4 wraps modulo 2**PC_W.
  - mispredict_count increments once per M and holds at all-ones.
- ex_valid=0: no table change, no redirect, regardless of the other EX inputs.

Optional Feature:
- Macro BP_BTB_TAG_EN.
- When defined:
  - Each BTB entry stores tag = pc[PC_W-1:IDX_W+2].
  - A prediction hit additionally requires a tag match.
  - A taken update writes the tag.
  - Non-branch clearing only occurs when the tag matches.
- When undefined: no tag storage; aliasing PCs share entries.

Decomposition:
- Package riscv_bp_pkg holds:
  - counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
  - CNT_RESET=WNT;
  - PC_STEP=4.
- Sub-module bp_sat_counter2: 2-bit saturating next-state function (inputs cur, taken; output next), instantiated per update path.

Test Plan:
- Reset, then lookup if_pc=0x100 -> pred_taken=0, pred_target=0x104, redirect=0, mispredict_count=0.
- Branch at 0x100 resolves taken, target 0x200, pred_taken=0 -> next cycle redirect=1, redirect_pc=0x200, count=1; counter WNT->WT, so a later lookup of 0x100 gives pred_taken=1, pred_target=0x200.
- Three further taken updates at 0x100 -> counter stays ST; one not-taken with pred_taken=1 -> redirect_pc=0x104, counter ST->WT, prediction still taken.
- Predicted-taken non-branch at 0x140 (ex_branch=0, ex_pred_taken=1) -> redirect_pc=0x144, entry invalidated, next lookup of 0x140 gives pred_taken=0.
- Taken correctly predicted but ex_pred_target=0x300 vs ex_target=0x200 -> redirect_pc=0x200, BTB updated to 0x200.
- Same-cycle lookup and update of index 0x100 -> IF sees old prediction; rst_n pulsed while redirect=1 -> redirect=0 immediately and the table returns to the reset state.
